spi_burst_master: RTL
=====================

Name: spi_burst_master

Overview:
- Parametrised SPI master that clocks a configurable burst of bytes full-duplex: shifts out a latched tx word on mosi and captures miso into an rx word.
- Timing is paced by the one-clk-wide enable `divided_clk`, with a programmable slave-select setup delay and inter-byte gap.
- Adds a start/busy handshake, selectable clock polarity, and a stable output word published with a one-cycle valid pulse.
- Sits between the system divider and sensor/peripheral consumers on the `clk` domain.

Parameters:
- NUM_BYTES, 5, bytes per transaction (>=1).
- START_DELAY, 30, divided_clk ticks between ss falling and the first sck edge (>=1).
- BYTE_GAP, 20, divided_clk ticks of idle sck between bytes (>=1).
- CPOL, 0, sck idle level (0 or 1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- divided_clk  input  1  tick enable; one clk cycle wide; all SPI timing advances only when high.
- start  input  1  request a transaction; honoured when busy=0.
- tx_data  input  8*NUM_BYTES  outgoing word; byte 0 = MSBs, MSB-first on the wire.
- miso  input  1  serial data from slave.
- ss  output  1  slave select, active low.
- sck  output  1  SPI clock.
- mosi  output  1  serial data to slave.
- busy  output  1  high from accepted start until valid.
- valid  output  1  one clk-cycle pulse; data updated on the same edge.
- data  output  8*NUM_BYTES  received word; first byte received = MSBs; holds until the next valid.

Behaviour:
- Reset (async, any time, including mid-transfer): state=IDLE, ss=1, sck=CPOL, mosi=1, busy=0, valid=0, data=0, counters and shift registers cleared. No valid is produced for an aborted burst.
- IDLE: start=1 on any clk edge (tick not required):
  - latch tx_data into tx shift register;
  - ss<=0, busy<=1, mosi<=tx bit MSB, counter<=0, state<=START;
  - start while busy=1 is ignored.
- START: counts ticks; on the tick where counter==START_DELAY-1, counter<=0, state<=BYTE.
- BYTE: 16 ticks per byte, alternating two phases starting with leading:
  - leading tick: sck<=~CPOL;
  - trailing tick: sck<=CPOL; rx shift <= {rx[..],miso}; tx shift advances; mosi<=next tx bit (1 after the final bit).
  - After the 8th trailing tick: if byte index==NUM_BYTES-1, state<=END; else byte index++, counter<=0, state<=GAP.
- GAP: sck held at CPOL, ss low; on the tick where counter==BYTE_GAP-1, state<=BYTE.
- END (next tick): ss<=1, mosi<=1, data<=rx shift, valid<=1 for exactly one clk, busy<=0, state<=IDLE.
- valid falls on the following clk edge regardless of divided_clk.
- A new start is accepted on the first clk edge after busy falls, so ss high time is at least 1 clk.
- Outputs are registered. Between ticks, nothing changes except start acceptance and valid clearing.
- divided_clk is ignored in IDLE, except under AUTO_POLL_EN.
- Counter widths: $clog2 of max(START_DELAY, BYTE_GAP, 16) + 1. Byte index width: $clog2(NUM_BYTES)+1. No wrap occurs within legal parameters.
- Total ticks from acceptance to ss rising: START_DELAY + 16*NUM_BYTES + BYTE_GAP*(NUM_BYTES-1) + 1.

Optional Feature:
- Macro: SPI_BURST_AUTO_POLL_EN.
- Defined: free-running poll.
  - In IDLE, every divided_clk tick starts a transaction as if start=1 (tx_data relatched each time); the start port is ignored.
  - ss stays high for exactly one tick period between bursts.
  - busy stays high except during that IDLE interval.
- Undefined: transactions occur only on start, as described above.

Test Plan:
- Use NUM_BYTES=2, START_DELAY=3, BYTE_GAP=2, CPOL=0, divided_clk high 1 of every 4 clk.
- Loopback: tie miso to mosi, tx_data=16'hA55A, pulse start -> 16 sck rising edges, mosi bit pattern 1010010101011010, ss high on the 38th tick after acceptance, valid one clk, data=16'hA55A.
- Slave model returns 8'h3C then 8'hF0 sampled on sck falling -> data=16'h3CF0. Measure: sck idle between the bytes for exactly 2 ticks; ss-to-first-sck-rise exactly 3 ticks.
- CPOL=1, same stimulus -> sck idles high, 16 falling-then-rising pairs, identical data.
- Second start pulse mid-burst, then rst asserted during byte 1 -> busy/ss/sck/valid return to reset values immediately (async), data=0, no valid pulse.
- Back-to-back: start held high continuously -> ss high for exactly 1 clk between bursts, valid once per burst. With SPI_BURST_AUTO_POLL_EN and start=0 -> bursts repeat with ss high for exactly 1 tick period.

Source files
------------

// File: rtl/spi_burst_master.sv
// Full-duplex SPI burst master paced by the divided_clk tick enable.
// Optional free-running poll mode: define SPI_BURST_AUTO_POLL_EN.
module spi_burst_master #(
    parameter int NUM_BYTES   = 5,
    parameter int START_DELAY = 30,
    parameter int BYTE_GAP    = 20,
    parameter int CPOL        = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   divided_clk,
    input  logic                   start,
    input  logic [8*NUM_BYTES-1:0] tx_data,
    input  logic                   miso,
    output logic                   ss,
    output logic                   sck,
    output logic                   mosi,
    output logic                   busy,
    output logic                   valid,
    output logic [8*NUM_BYTES-1:0] data
);

    localparam int W       = 8 * NUM_BYTES;
    localparam int MAX_SD  = (START_DELAY > 16) ? START_DELAY : 16;
    localparam int MAX_CNT = (BYTE_GAP > MAX_SD) ? BYTE_GAP : MAX_SD;
    localparam int CW      = $clog2(MAX_CNT) + 1;
    localparam int BW      = $clog2(NUM_BYTES) + 1;
    localparam logic IDLE_LVL = (CPOL != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BYTE,
        S_GAP,
        S_END
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [BW-1:0]   bidx, bidx_nxt;
    logic [W-2:0]    tx_rem, tx_rem_nxt;
    logic [W-1:0]    rx_sr, rx_sr_nxt;
    logic [W-1:0]    data_nxt;
    logic            ss_nxt, sck_nxt, mosi_nxt, busy_nxt, valid_nxt;
    logic            go;

`ifdef SPI_BURST_AUTO_POLL_EN
    logic unused_start;
    assign unused_start = start;
    assign go           = divided_clk;
`else
    assign go = start;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            bidx   <= '0;
            tx_rem <= '0;
            rx_sr  <= '0;
            ss     <= 1'b1;
            sck    <= IDLE_LVL;
            mosi   <= 1'b1;
            busy   <= 1'b0;
            valid  <= 1'b0;
            data   <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            bidx   <= bidx_nxt;
            tx_rem <= tx_rem_nxt;
            rx_sr  <= rx_sr_nxt;
            ss     <= ss_nxt;
            sck    <= sck_nxt;
            mosi   <= mosi_nxt;
            busy   <= busy_nxt;
            valid  <= valid_nxt;
            data   <= data_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        bidx_nxt   = bidx;
        tx_rem_nxt = tx_rem;
        rx_sr_nxt  = rx_sr;
        ss_nxt     = ss;
        sck_nxt    = sck;
        mosi_nxt   = mosi;
        busy_nxt   = busy;
        valid_nxt  = 1'b0;
        data_nxt   = data;

        case (state)
            S_IDLE: begin
                if (go) begin
                    // MSB goes straight to mosi; tx_rem holds the bits still to send
                    tx_rem_nxt = tx_data[W-2:0];
                    mosi_nxt   = tx_data[W-1];
                    ss_nxt     = 1'b0;
                    busy_nxt   = 1'b1;
                    cnt_nxt    = '0;
                    bidx_nxt   = '0;
                    rx_sr_nxt  = '0;
                    state_nxt  = S_START;
                end
            end

            S_START: begin
                if (divided_clk) begin
                    if (cnt == CW'(START_DELAY - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = S_BYTE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            S_BYTE: begin
                if (divided_clk) begin
                    if (!cnt[0]) begin
                        sck_nxt = ~IDLE_LVL;
                        cnt_nxt = cnt + 1'b1;
                    end else begin
                        // trailing phase: sample, then present next bit (1s fill past the end)
                        sck_nxt    = IDLE_LVL;
                        rx_sr_nxt  = {rx_sr[W-2:0], miso};
                        mosi_nxt   = tx_rem[W-2];
                        tx_rem_nxt = {tx_rem[W-3:0], 1'b1};
                        if (cnt == CW'(15)) begin
                            cnt_nxt = '0;
                            if (bidx == BW'(NUM_BYTES - 1)) begin
                                state_nxt = S_END;
                            end else begin
                                bidx_nxt  = bidx + 1'b1;
                                state_nxt = S_GAP;
                            end
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
            end

            S_GAP: begin
                if (divided_clk) begin
                    if (cnt == CW'(BYTE_GAP - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = S_BYTE;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end

            S_END: begin
                if (divided_clk) begin
                    ss_nxt    = 1'b1;
                    mosi_nxt  = 1'b1;
                    data_nxt  = rx_sr;
                    valid_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
